// File: rtl/pps_error_formatter.sv
// pps_error_formatter: renders each signed clock-error sample as an ASCII line
// "<sign><hex digits>\r\n" and feeds it byte by byte to a txuart over stb/busy.
//  clk        system clock
//  rst        asynchronous active-high reset
//  i_valid    one-cycle strobe, i_error holds a new sample
//  i_error    two's-complement clock error (WIDTH bits)
//  i_busy     txuart busy
//  o_stb      byte request to txuart
//  o_data     byte to transmit, stable while o_stb=1
//  o_active   a line is in progress
//  o_dropped  one-cycle pulse when a pending sample is overwritten
module pps_error_formatter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_error,
    input  logic             i_busy,
    output logic             o_stb,
    output logic [7:0]       o_data,
    output logic             o_active,
    output logic             o_dropped
);
    localparam int NDIGITS = WIDTH / 4;
    localparam int IW = $clog2(NDIGITS + 3);
    localparam logic [IW-1:0] LAST = IW'(NDIGITS + 2);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, WAIT} state_t;

    state_t           state;
    logic [WIDTH-1:0] line;
    logic [WIDTH-1:0] pend;
    logic             pend_full;
    logic [WIDTH-1:0] mag;
    logic             neg;
    logic [IW-1:0]    idx;
    logic             xfer;

    // End of line with a queued sample: pending moves into the line register this cycle
    assign xfer = state == WAIT && !i_busy && idx == LAST && pend_full;

    // Byte k of the line: sign, NDIGITS hex digits MSB first, CR, LF
    function automatic logic [7:0] byte_of(input logic [IW-1:0] k);
        logic [3:0] n;
        n = 4'(mag >> (4 * (NDIGITS - int'(k))));
        byte_of = k == '0 ? (neg ? 8'h2D : 8'h2B) :
                  k <= IW'(NDIGITS) ? (n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n}) :
                  k == IW'(NDIGITS + 1) ? 8'h0D : 8'h0A;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            line      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            mag       <= '0;
            neg       <= 1'b0;
            idx       <= '0;
            o_stb     <= 1'b0;
            o_data    <= 8'h00;
            o_active  <= 1'b0;
            o_dropped <= 1'b0;
        end else begin
            o_dropped <= 1'b0;
            case (state)
                IDLE: if (i_valid) begin
                    line     <= i_error;
                    o_active <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: begin
                    // Negation at WIDTH bits leaves the most negative value as its own magnitude
                    mag    <= line[WIDTH-1] ? -line : line;
                    neg    <= line[WIDTH-1];
                    idx    <= '0;
                    o_data <= line[WIDTH-1] ? 8'h2D : 8'h2B;
                    o_stb  <= 1'b1;
                    state  <= SEND;
                end
                SEND: if (!i_busy) begin
                    o_stb <= 1'b0;
                    state <= GAP;
                end
                // One dead cycle so txuart's registered busy is visible before we look at it
                GAP: state <= WAIT;
                WAIT: if (!i_busy) begin
                    if (idx != LAST) begin
                        idx    <= idx + 1'b1;
                        o_data <= byte_of(idx + 1'b1);
                        o_stb  <= 1'b1;
                        state  <= SEND;
                    end else if (pend_full) begin
                        line  <= pend;
                        state <= LOAD;
                    end else begin
                        o_active <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A sample arriving on the transfer cycle lands in the freshly emptied slot
            if (i_valid && state != IDLE) begin
                pend      <= i_error;
                pend_full <= 1'b1;
                o_dropped <= pend_full && !xfer;
            end else if (xfer) begin
                pend_full <= 1'b0;
            end
        end
    end
endmodule
